// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: PC/IR/status owner for the SISC core, fetching over a req/ack handshake and resolving branches
module sisc_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              TIMEOUT  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            fetch_go,
    input  logic            br_req,
    input  logic            stat_en,
    input  logic [3:0]      alu_stat,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [3:0]      rd,
    output logic [3:0]      rs,
    output logic [3:0]      rt,
    output logic [15:0]     imm,
    output logic [3:0]      stat,
    output logic [PC_W-1:0] pc,
    output logic            ir_valid,
    output logic            br_taken,
    output logic            fetch_err
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic {IDLE, REQ} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [3:0]      stat_q, stat_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            br_q, br_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout;
    logic            cond;
    logic            taken;
    logic [3:0]      op;
    logic [PC_W-1:0] target;
    assign op      = ir_q[31:28];
    assign timeout = (state_q == REQ) && !imem_ack && (cnt_q == CW'(TIMEOUT - 1));
    assign cond    = |(stat_q & ir_q[27:24]);
    assign taken   = ((op == 4'd4 || op == 4'd5) && cond) || ((op == 4'd6 || op == 4'd7) && !cond);
    // odd branch opcodes (BRR/BNR) are PC-relative, even ones (BRA/BNE) are absolute
    assign target  = op[0] ? pc_q + PC_W'($signed(ir_q[15:0])) : PC_W'(ir_q[15:0]);
    // state and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            stat_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            br_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            stat_q  <= stat_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            br_q    <= br_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    // next state: a branch request in IDLE swallows a simultaneous fetch_go
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (fetch_go && !br_req) ? REQ : IDLE;
        else
            state_d = (imem_ack || timeout) ? IDLE : REQ;
    end
    // registered outputs and datapath updates for fetch, timeout and branch
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        stat_d  = stat_en ? alu_stat : stat_q;
        req_d   = req_q;
        valid_d = valid_q;
        br_d    = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (br_req) begin
                pc_d = taken ? target : pc_q;
                br_d = taken;
            end else if (fetch_go) begin
                req_d   = 1'b1;
                valid_d = 1'b0;
                err_d   = 1'b0;
                cnt_d   = '0;
            end
        end else if (imem_ack) begin
            ir_d    = imem_data;
            pc_d    = pc_q + PC_W'(1);
            valid_d = 1'b1;
            req_d   = 1'b0;
        end else if (timeout) begin
            ir_d    = '0;
            pc_d    = pc_q + PC_W'(1);
            err_d   = 1'b1;
            valid_d = 1'b1;
            req_d   = 1'b0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign opcode    = ir_q[31:28];
    assign mm        = ir_q[27:24];
    assign rd        = ir_q[23:20];
    assign rs        = ir_q[19:16];
    assign rt        = ir_q[15:12];
    assign imm       = ir_q[15:0];
    assign stat      = stat_q;
    assign pc        = pc_q;
    assign ir_valid  = valid_q;
    assign br_taken  = br_q;
    assign fetch_err = err_q;
endmodule

// File: tb/tb_sisc_fetch_unit.sv
// tb_sisc_fetch_unit: scoreboard bench with an abstract PC/IR/status model for sisc_fetch_unit
module tb_sisc_fetch_unit;
    localparam int PC_W = 16;
    localparam int TO   = 8;
    typedef logic [75:0] vec_t;

    logic            clk = 1'b0, rst_f = 1'b0;
    logic            fetch_go = 1'b0, br_req = 1'b0, stat_en = 1'b0, imem_ack = 1'b0;
    logic [3:0]      alu_stat = '0;
    logic [31:0]     imem_data = '0;
    logic            imem_req, ir_valid, br_taken, fetch_err;
    logic [PC_W-1:0] imem_addr, pc;
    logic [3:0]      opcode, mm, rd, rs, rt, stat;
    logic [15:0]     imm;

    sisc_fetch_unit #(.PC_W(PC_W), .TIMEOUT(TO), .RESET_PC('0)) dut (
        .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .br_req(br_req), .stat_en(stat_en),
        .alu_stat(alu_stat), .imem_ack(imem_ack), .imem_data(imem_data), .imem_req(imem_req),
        .imem_addr(imem_addr), .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .stat(stat), .pc(pc), .ir_valid(ir_valid), .br_taken(br_taken), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    vec_t        exp_q[$];
    string       nm_q[$];
    int          total = 0, bad = 0;
    int          m_pc;
    logic [31:0] m_ir;
    logic [3:0]  m_stat;
    logic        m_err, m_valid;
    logic        snap = 1'b0, done = 1'b0, br_seen = 1'b0;

    function automatic void push(string n, logic br, logic req);
        logic [15:0] p;
        p = 16'(m_pc);
        exp_q.push_back({p, m_ir, m_ir[15:12], m_stat, br, m_err, m_valid, req, p});
        nm_q.push_back(n);
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_ir = '0; m_stat = '0; m_err = 1'b0; m_valid = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    always @(posedge clk) br_seen <= br_req;

    // monitor: one expectation per fetch completion, branch response or explicit snapshot
    initial begin
        vec_t  act, e;
        string n;
        logic  req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            act = {pc, opcode, mm, rd, rs, imm, rt, stat, br_taken, fetch_err, ir_valid, imem_req, imem_addr};
            if ((req_prev && !imem_req) || br_seen || snap) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event got=%h required=none", act);
                end else begin
                    e = exp_q.pop_front();
                    n = nm_q.pop_front();
                    if (act !== e) begin
                        bad++;
                        $display("FAIL %s got=%h required=%h", n, act, e);
                    end
                end
            end
            req_prev = imem_req;
            if (done) begin
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL leftover_expectations got=%0d required=0", exp_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // fetch with ack after j waiting cycles; j >= TO means the ack arrives too late
    task automatic do_fetch(string n, logic [31:0] d, int j, bit extra);
        bit ex;
        ex = extra && (j >= 1);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        m_valid = 1'b0;
        m_err = 1'b0;
        if (ex) push({n, "_inreq"}, 1'b0, 1'b1);
        m_pc = (m_pc + 1) % 65536;
        if (j < TO) m_ir = d;
        else begin
            m_ir = '0;
            m_err = 1'b1;
        end
        m_valid = 1'b1;
        push(n, 1'b0, 1'b0);
        for (int k = 0; k < j; k++) begin
            if (k == 0 && ex) begin
                br_req = 1'b1;
                fetch_go = 1'b1;
            end
            imem_data = $urandom;
            tick();
            br_req = 1'b0;
            fetch_go = 1'b0;
        end
        imem_ack = 1'b1;
        imem_data = d;
        tick();
        imem_ack = 1'b0;
        tick();
    endtask

    task automatic do_branch(string n, bit sen, logic [3:0] sv, bit go);
        int         op, ui, si, t;
        logic [3:0] mmv;
        bit         c, tk;
        op  = int'(m_ir[31:28]);
        mmv = m_ir[27:24];
        ui  = int'(m_ir[15:0]);
        si  = int'($signed(m_ir[15:0]));
        c   = (m_stat & mmv) != 4'd0;
        tk  = ((op == 4 || op == 5) && c) || ((op == 6 || op == 7) && !c);
        t   = m_pc;
        if (tk) t = (op == 4 || op == 6) ? ui : ((m_pc + si) & 65535);
        m_pc = t;
        if (sen) m_stat = sv;
        push(n, tk, 1'b0);
        br_req = 1'b1;
        stat_en = sen;
        alu_stat = sv;
        fetch_go = go;
        tick();
        br_req = 1'b0;
        stat_en = 1'b0;
        fetch_go = 1'b0;
        tick();
    endtask

    task automatic do_stat(string n, logic [3:0] v);
        stat_en = 1'b1;
        alu_stat = v;
        tick();
        stat_en = 1'b0;
        m_stat = v;
        push(n, 1'b0, 1'b0);
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic do_reset_midreq();
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        tick();
        rst_f = 1'b0;
        model_reset();
        push("rst_midreq", 1'b0, 1'b0);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        rst_f = 1'b1;
        imem_ack = 1'b1;
        imem_data = 32'hF123_4567;
        tick();
        imem_ack = 1'b0;
        push("late_ack_ignored", 1'b0, 1'b0);
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    // driver: directed scenarios, then randomized operations
    initial begin
        logic [31:0] d;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push("reset", 1'b0, 1'b0);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        rst_f = 1'b1;
        tick();
        do_fetch("f_basic", 32'h8123_4005, 2, 1'b0);
        do_fetch("f_timeout", 32'h1111_1111, TO, 1'b0);
        do_fetch("f_clrerr", 32'h4200_0040, 1, 1'b1);
        do_stat("stat2", 4'b0010);
        do_branch("bra_taken", 1'b0, 4'd0, 1'b0);
        do_fetch("f_bra_mm4", 32'h4400_0040, 0, 1'b0);
        do_branch("bra_not_taken", 1'b0, 4'd0, 1'b0);
        do_fetch("f_bra10", 32'h4F00_000F, 3, 1'b0);
        do_branch("bra_to_0f", 1'b0, 4'd0, 1'b0);
        do_fetch("f_bnr", 32'h7100_FFFC, 1, 1'b0);
        do_stat("stat0", 4'd0);
        do_branch("bnr_taken", 1'b0, 4'd0, 1'b0);
        do_stat("stat1", 4'd1);
        do_fetch("f_bnr2", 32'h7100_FFFC, 1, 1'b0);
        do_branch("bnr_not_taken", 1'b0, 4'd0, 1'b0);
        do_fetch("f_top", 32'h4100_FFFF, 1, 1'b0);
        do_branch("bra_top", 1'b0, 4'd0, 1'b0);
        do_fetch("f_wrap_ack_at_limit", 32'h4200_1234, TO - 1, 1'b0);
        do_branch("old_stat_used", 1'b1, 4'hA, 1'b1);
        do_reset_midreq();
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    d = $urandom;
                    if ($urandom_range(0, 2) != 0) d[31:28] = 4'(4 + $urandom_range(0, 3));
                    do_fetch("rnd_fetch", d, int'($urandom_range(0, TO + 1)), 1'($urandom_range(0, 1)));
                end
                5, 6, 7: do_branch("rnd_branch", 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
                default: do_stat("rnd_stat", 4'($urandom));
            endcase
        end
        repeat (3) tick();
        done = 1'b1;
        tick();
    end
endmodule
